// File: rtl/bru_bpu_pkg.sv
// bru_bpu_pkg: shared widths, branch funct3 codes, counter states and BTB entry layout
package bru_bpu_pkg;
  localparam int P_XLEN = 64;
  localparam int P_TAGW = 12;
  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  typedef struct packed {
    logic              valid;
    logic [P_TAGW-1:0] tag;
    logic [P_XLEN-1:0] target;
    ctr_e              ctr;
    logic              uncond;
  } btb_entry_t;
endpackage

// File: rtl/bru_bpu_cmp.sv
// bru_cmp: conditional branch outcome from funct3 and the two forwarded operands
module bru_cmp
  import bru_bpu_pkg::*;
#(
  parameter int XLEN = P_XLEN
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken
);
  logic [XLEN:0] w_udiff;
  logic          w_eq;
  logic          w_ltu;
  logic          w_lt;
  assign w_udiff = {1'b0, i_rs1} - {1'b0, i_rs2};
  assign w_eq    = ~|w_udiff[XLEN-1:0];
  assign w_ltu   = w_udiff[XLEN];
  assign w_lt    = (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]) ? i_rs1[XLEN-1] : w_ltu;
  // undefined funct3 codes resolve as not taken
  always_comb
    o_taken = (i_funct3 == FUNC3_BEQ)  ?  w_eq  :
              (i_funct3 == FUNC3_BNE)  ? ~w_eq  :
              (i_funct3 == FUNC3_BLT)  ?  w_lt  :
              (i_funct3 == FUNC3_BGE)  ? ~w_lt  :
              (i_funct3 == FUNC3_BLTU) ?  w_ltu :
              (i_funct3 == FUNC3_BGEU) ? ~w_ltu : 1'b0;
endmodule

// File: rtl/bru_bpu.sv
// bru_bpu: BTB-based next-PC prediction at IF, control-flow resolution and redirect at ID
module bru_bpu
  import bru_bpu_pkg::*;
#(
  parameter int XLEN  = P_XLEN,
  parameter int DEPTH = 16,
  parameter int TAGW  = P_TAGW,
  parameter int CNTW  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ifu_valid,
  input  logic [XLEN-1:0] i_ifu_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_pc,
  input  logic            i_idu_valid,
  input  logic [XLEN-1:0] i_idu_pc,
  input  logic            i_idu_pred_taken,
  input  logic [XLEN-1:0] i_idu_pred_pc,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_brch,
  input  logic [2:0]      i_bfun3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [CNTW-1:0] o_mispred_cnt
);
  localparam int IDXW = $clog2(DEPTH);
  btb_entry_t      r_btb [DEPTH];
  logic [CNTW-1:0] r_cnt;
  logic [IDXW-1:0] w_if_idx, w_id_idx;
  logic [TAGW-1:0] w_if_tag, w_id_tag;
  logic            w_if_hit, w_id_hit, w_ctl, w_brt, w_act_taken, w_mis;
  logic [XLEN-1:0] w_jalr_pc, w_act_pc;
  ctr_e            w_ctr, w_ctr_nxt;
  assign w_if_idx = i_ifu_pc[IDXW+1:2];
  assign w_if_tag = i_ifu_pc[IDXW+2 +: TAGW];
  assign w_id_idx = i_idu_pc[IDXW+1:2];
  assign w_id_tag = i_idu_pc[IDXW+2 +: TAGW];
  assign w_if_hit = i_ifu_valid && r_btb[w_if_idx].valid && r_btb[w_if_idx].tag == w_if_tag;
  assign w_id_hit = r_btb[w_id_idx].valid && r_btb[w_id_idx].tag == w_id_tag;
  assign o_pred_taken = w_if_hit && (r_btb[w_if_idx].uncond || r_btb[w_if_idx].ctr[1]);
  assign o_pred_pc    = o_pred_taken ? r_btb[w_if_idx].target : i_ifu_pc + XLEN'(4);
  bru_cmp #(.XLEN(XLEN)) u_cmp (
    .i_funct3 (i_bfun3),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_taken  (w_brt)
  );
  assign w_ctl       = i_jal | i_jalr | i_brch;
  assign w_act_taken = i_idu_valid & (i_jal | i_jalr | (i_brch & w_brt));
  assign w_jalr_pc   = (i_rs1 + i_imm) & ~XLEN'(1);
  assign w_act_pc    = i_jalr ? w_jalr_pc : w_act_taken ? i_idu_pc + i_imm : i_idu_pc + XLEN'(4);
  // a non-control instruction predicted taken falls out here as a taken/not-taken mismatch
  assign w_mis         = (i_idu_pred_taken != w_act_taken) || (w_act_taken && i_idu_pred_pc != w_act_pc);
  assign o_redirect    = i_idu_valid & w_mis;
  assign o_redirect_pc = w_act_pc;
  assign o_mispred_cnt = r_cnt;
  // saturating step of the direction counter toward the resolved outcome
  always_comb begin
    w_ctr     = r_btb[w_id_idx].ctr;
    w_ctr_nxt = w_act_taken ? ((w_ctr == ST) ? ST : ctr_e'(w_ctr + 2'd1))
                            : ((w_ctr == SNT) ? SNT : ctr_e'(w_ctr - 2'd1));
  end
  // single write port: train on hit, allocate on taken miss, drop aliased entries
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_btb[k].valid <= 1'b0;
        r_btb[k].ctr   <= SNT;
      end
    end else if (i_idu_valid) begin
      if (w_id_hit && !w_ctl) begin
        r_btb[w_id_idx].valid <= 1'b0;
      end else if (w_id_hit) begin
        if (i_brch) r_btb[w_id_idx].ctr <= w_ctr_nxt;
        if (w_act_taken) r_btb[w_id_idx].target <= w_act_pc;
      end else if (w_act_taken) begin
        r_btb[w_id_idx] <= '{valid: 1'b1, tag: w_id_tag, target: w_act_pc, ctr: WT, uncond: i_jal | i_jalr};
      end
    end
  end
  // misprediction statistics, clamped at all-ones
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else if (o_redirect && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
endmodule
